// File: rtl/array_pkg.sv
// Shared definitions for the array loader and the downstream array-sum stage.
package array_pkg;

    localparam int N = 10;  // elements per operand array
    localparam int W = 8;   // element width

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/array_loader_if.sv
// Element stream in, operand-array pair out.
interface array_loader_if #(
    parameter int N = array_pkg::N,
    parameter int W = array_pkg::W
);

    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           abort;
    logic [N*W-1:0] num1;
    logic [N*W-1:0] num2;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, num1, num2, out_valid
    );

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, num1, num2, out_valid
    );

endinterface

// File: rtl/array_loader.sv
// Collects a 2*N element frame: first N elements into num1, next N into num2,
// first-received element in the most-significant slot. Holds the frame until
// the sum stage takes it.
module array_loader
    import array_pkg::*;
#(
    parameter int N = array_pkg::N,
    parameter int W = array_pkg::W
) (
    input  logic           clk,
    input  logic           res,
    array_loader_if.slave  bus
);

    localparam int            IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   slot_a [N];
    logic [W-1:0]   slot_b [N];
    logic [N-1:0]   sel;
    logic           wr_a, wr_b;
    logic           in_ready, out_valid;

    // state and element index registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // next state, handshake outputs and slot write strobes; abort wins over
    // a same-cycle element so that element is dropped
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        case (state_q)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                if (bus.abort) begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end else if (bus.in_valid) begin
                    wr_a = (state_q == LOAD_A);
                    wr_b = (state_q == LOAD_B);
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = LOAD_A;
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    // element k lands in slot N-1-k, so the first element ends up on top
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) sel[i] = (idx_q == IW'(N - 1 - i));
    end

    // slot registers; untouched slots keep the previous frame's data
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < N; i++) begin
                slot_a[i] <= '0;
                slot_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_a && sel[i]) slot_a[i] <= bus.in_data;
                if (wr_b && sel[i]) slot_b[i] <= bus.in_data;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign bus.num1[g*W +: W] = slot_a[g];
        assign bus.num2[g*W +: W] = slot_b[g];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_array_loader.sv
// Scoreboard bench for array_loader: a frame-level model predicts handshake
// levels every cycle and queues the expected operand pair per completed frame;
// a monitor pops and compares whenever out_valid rises.
module tb_array_loader;
    import array_pkg::*;

    localparam int NW = N * W;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    array_loader_if bus ();

    array_loader dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: accepted elements of the current frame, hold flag
    logic [W-1:0]  m_buf [$];
    bit            m_hold = 1'b0;
    logic [NW-1:0] exp1_q [$];
    logic [NW-1:0] exp2_q [$];
    int            pushed = 0;
    int            rises  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // one clock: drive at negedge, check handshake levels, advance the model
    task automatic step(input logic v, input logic [W-1:0] d, input logic ab,
                        input logic ordy, input logic rs);
        logic [NW-1:0] a, b;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.abort     = ab;
        bus.out_ready = ordy;
        res           = rs;
        chk("in_ready", bus.in_ready, !m_hold);
        chk("out_valid", bus.out_valid, m_hold);
        @(posedge clk);
        if (rs) begin
            m_hold = 1'b0;
            m_buf.delete();
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (ab) begin
            m_buf.delete();
        end else if (v) begin
            m_buf.push_back(d);
            if (m_buf.size() == 2 * N) begin
                a = '0;
                b = '0;
                for (int k = 0; k < N; k++) begin
                    a[(N-1-k)*W +: W] = m_buf[k];
                    b[(N-1-k)*W +: W] = m_buf[N+k];
                end
                exp1_q.push_back(a);
                exp2_q.push_back(b);
                pushed++;
                m_hold = 1'b1;
                m_buf.delete();
            end
        end
    endtask

    task automatic send(input logic [W-1:0] q [$], input bit gap);
        foreach (q[i]) begin
            step(1'b1, q[i], 1'b0, 1'b0, 1'b0);
            if (gap) step(1'b0, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_const(input string nm, input logic [NW-1:0] e1, input logic [NW-1:0] e2);
        #1;
        chk({nm, "_num1"}, bus.num1, e1);
        chk({nm, "_num2"}, bus.num2, e2);
    endtask

    task automatic release_frame();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // monitor: compare each presented frame against the scoreboard, then
    // require the outputs to stay put for as long as out_valid is high
    bit            ov_prev = 1'b0;
    logic [NW-1:0] snap1, snap2;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (!ov_prev) begin
                rises++;
                if (exp1_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got num1=%0h want no frame", bus.num1);
                end else begin
                    chk("sb_num1", bus.num1, exp1_q.pop_front());
                    chk("sb_num2", bus.num2, exp2_q.pop_front());
                end
                snap1 = bus.num1;
                snap2 = bus.num2;
            end else begin
                chk("hold_num1", bus.num1, snap1);
                chk("hold_num2", bus.num2, snap2);
            end
        end
        ov_prev = (bus.out_valid === 1'b1);
    end

    initial begin
        logic [W-1:0] f1 [$];
        logic [W-1:0] f2 [$];
        logic [W-1:0] fr [$];
        int r0;

        for (int k = 0; k < N; k++) f1.push_back(W'(2 * (k + 1)));
        for (int k = 0; k < N; k++) f1.push_back(W'(2 * k + 1));
        f2 = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int k = 1; k <= N; k++) f2.push_back(W'(k));

        res           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_num1", bus.num1, '0);
        chk("rst_num2", bus.num2, '0);
        chk("rst_out_valid", bus.out_valid, 1'b0);

        // back-to-back frame
        send(f1, 1'b0);
        chk_const("b2b", 80'h020406080A0C0E101214, 80'h01030507090B0D0F1113);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        release_frame();

        // same frame with a gap after every element
        r0 = rises;
        send(f1, 1'b1);
        chk_const("gap", 80'h020406080A0C0E101214, 80'h01030507090B0D0F1113);
        release_frame();
        chk("gap_one_valid", rises - r0, 1);

        // long hold with in_valid pushing
        fr.delete();
        for (int k = 0; k < 2 * N; k++) fr.push_back(W'($urandom));
        send(fr, 1'b0);
        repeat (50) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        release_frame();

        // abort after 13 elements, element in the abort cycle is dropped
        for (int k = 0; k < 13; k++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        send(f2, 1'b0);
        chk_const("abort", 80'h05040302010102030405, 80'h0102030405060708090A);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);  // abort ignored in hold
        release_frame();

        // reset after 15 elements, then a fresh frame
        for (int k = 0; k < 15; k++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        fr.delete();
        for (int k = 0; k < 2 * N; k++) fr.push_back(W'($urandom));
        send(fr, 1'b0);
        release_frame();

        // random traffic
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);

        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("frames_seen", rises, pushed);
        chk("sb_empty", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_loader.md
ARRAY_LOADER -- requirements
Module: array_loader

Interface
REQ-001 Parameter N, default 10, number of elements per operand array.
REQ-002 Parameter W, default 8, element width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream byte-stream element valid.
REQ-006 in_data  input  W  element value.
REQ-007 in_ready  output  1  loader can accept an element this cycle.
REQ-008 abort  input  1  discard the partially loaded frame.
REQ-009 num1  output  N*W  packed operand array A, fed to the array-sum stage.
REQ-010 num2  output  N*W  packed operand array B, fed to the array-sum stage.
REQ-011 out_valid  output  1  num1/num2 hold a complete frame.
REQ-012 out_ready  input  1  downstream sum stage has consumed the frame.

Function
REQ-013 An element transfers only on a rising edge with in_valid=1 and in_ready=1.
REQ-014 A frame is 2*N elements: the first N go to num1, the next N go to num2.
REQ-015 Within each array, the first element received goes to the most-significant slot: num1[N*W-1 -: W]; element k goes to slot N-1-k.
REQ-016 States: LOAD_A, LOAD_B, HOLD. Element index counter idx is 0..N-1, width clog2(N).
REQ-017 LOAD_A: in_ready=1. On the N-th transfer, idx wraps to 0 and the block moves to LOAD_B.
REQ-018 LOAD_B: in_ready=1. On the N-th transfer, idx wraps to 0, the block moves to HOLD, and out_valid rises in the following cycle (one-cycle latency from the last transfer).
REQ-019 HOLD: in_ready=0, out_valid=1, num1/num2 constant. When out_ready=1 on an edge, the block moves to LOAD_A and out_valid=0 next cycle.
REQ-020 num1/num2 are updated only by slot writes; slots not yet rewritten in a new frame keep their previous-frame values; out_valid alone qualifies the contents.
REQ-021 out_valid=0 in LOAD_A and LOAD_B; in_ready and out_valid are never both 1.
REQ-022 abort=1 in LOAD_A or LOAD_B sends the block to LOAD_A with idx=0; any element presented in the same cycle is dropped.
REQ-023 abort is ignored in HOLD.
REQ-024 res has priority over abort, in_valid and out_ready.
REQ-025 in_valid=0 stalls the load with no state change; gaps of any length are allowed.
REQ-026 in_data is stored unmodified; no arithmetic is done on it.

Reset
REQ-027 res=1 at a clock edge sets: state=LOAD_A, idx=0, num1=0, num2=0, out_valid=0.
REQ-028 in_ready=1 from the first cycle after reset.
REQ-029 Reset mid-load or in HOLD discards the frame with no out_valid pulse.

Structure
REQ-030 N, W and the state encoding (LOAD_A=2'd0, LOAD_B=2'd1, HOLD=2'd2) are defined in shared package array_pkg, which the array-sum stage also uses.
REQ-031 The design is a single module with no sub-modules; the slot write uses a decoded index into a register array that is flattened to num1/num2.

Verification
REQ-032 Reset, then stream 02,04,06,08,0A,0C,0E,10,12,14,01,03,05,07,09,0B,0D,0F,11,13 back-to-back -> out_valid rises 1 cycle after the 20th transfer, num1=80'h020406080A0C0E101214, num2=80'h01030507090B0D0F1113.
REQ-033 Same stream with in_valid low every other cycle -> identical num1/num2; out_valid is asserted exactly once.
REQ-034 Hold out_ready=0 for 50 cycles in HOLD while driving in_valid=1 -> in_ready=0 throughout, outputs unchanged; out_ready=1 -> LOAD_A, out_valid=0 next cycle.
REQ-035 Abort after 13 elements, then load 05,04,03,02,01,01,02,03,04,05,01..0A -> num1=80'h05040302010102030405, num2=80'h0102030405060708090A.
REQ-036 Assert res after 15 elements, then after 1 cycle load a full frame -> num1/num2 reflect only the new frame; no out_valid before its 20th transfer.
